// File: rtl/frame_decoder.sv
// frame_decoder
//   Pulls bytes from a receive queue and decodes framed sensor samples.
//   A frame is: header 0x00, tag byte, then payload. Tag 0x01 carries one
//   DIN byte; tags 0x02..0x05 (ADC0, ADC1, CADC0, CADC1) carry a 10-bit
//   sample as a low byte followed by a high byte of {6'b0, data[9:8]}.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_read, em_read     queue head byte and queue-empty flag
//   pp_read              pop strobe; the head byte is consumed this cycle
//   out_din / vld_din    last DIN byte and its one-cycle update strobe
//   out_adc0..out_cadc1  last 10-bit sample per channel
//   vld_adc0..vld_cadc1  one-cycle update strobe per channel
//   err_frame            one-cycle strobe on any framing violation
//   err_count            framing errors since reset, saturating at 0xFF
//   frame_count          good frames since reset, wrapping
//
// state | meaning
// ------+----------------------------------------------------------
// SYNC  | hunting for the 0x00 header
// TAG   | header seen, next byte selects the payload type
// LO    | expecting DIN byte or the low byte of a 10-bit sample
// HI    | expecting the high byte {6'b0, data[9:8]} of a 10-bit sample

module frame_decoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_read,
  input  logic        em_read,
  output logic        pp_read,
  output logic [7:0]  out_din,
  output logic        vld_din,
  output logic [9:0]  out_adc0,
  output logic [9:0]  out_adc1,
  output logic [9:0]  out_cadc0,
  output logic [9:0]  out_cadc1,
  output logic        vld_adc0,
  output logic        vld_adc1,
  output logic        vld_cadc0,
  output logic        vld_cadc1,
  output logic        err_frame,
  output logic [7:0]  err_count,
  output logic [15:0] frame_count
);

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_TAG  = 2'd1,
    ST_LO   = 2'd2,
    ST_HI   = 2'd3
  } state_t;

  localparam logic [2:0] TAG_DIN   = 3'd1;
  localparam logic [2:0] TAG_ADC0  = 3'd2;
  localparam logic [2:0] TAG_ADC1  = 3'd3;
  localparam logic [2:0] TAG_CADC0 = 3'd4;
  localparam logic [2:0] TAG_CADC1 = 3'd5;

  state_t      state;
  state_t      state_next;
  logic [2:0]  tag;
  logic [2:0]  tag_next;
  logic [7:0]  lo_buf;
  logic [7:0]  lo_next;
  logic        cooldown;
  logic        armed;
  logic        pop;

  logic        err_next;
  logic        vld_din_next;
  logic [3:0]  vld_ch_next;   // {cadc1, cadc0, adc1, adc0}
  logic [9:0]  sample_next;

  // armed keeps the first pop off until the first rising edge after reset
  // release; cooldown enforces one idle cycle after every pop.
  assign pop     = armed & ~cooldown & ~em_read;
  assign pp_read = pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_SYNC;
      tag      <= 3'd0;
      lo_buf   <= 8'd0;
      armed    <= 1'b0;
      cooldown <= 1'b0;
    end else begin
      state    <= state_next;
      tag      <= tag_next;
      lo_buf   <= lo_next;
      armed    <= 1'b1;
      cooldown <= pop;
    end
  end

  always_comb begin
    state_next   = state;
    tag_next     = tag;
    lo_next      = lo_buf;
    err_next     = 1'b0;
    vld_din_next = 1'b0;
    vld_ch_next  = 4'b0000;
    sample_next  = {in_read[1:0], lo_buf};

    if (pop) begin
      case (state)
        ST_SYNC: begin
          if (in_read == 8'h00) begin
            state_next = ST_TAG;
          end else begin
            err_next = 1'b1;
          end
        end

        ST_TAG: begin
          if ((in_read >= 8'h01) && (in_read <= 8'h05)) begin
            tag_next   = in_read[2:0];
            state_next = ST_LO;
          end else if (in_read == 8'h00) begin
            // repeated header: flag it but treat it as the start of a frame
            err_next = 1'b1;
          end else begin
            err_next   = 1'b1;
            state_next = ST_SYNC;
          end
        end

        ST_LO: begin
          if (tag == TAG_DIN) begin
            vld_din_next = 1'b1;
            state_next   = ST_SYNC;
          end else begin
            lo_next    = in_read;
            state_next = ST_HI;
          end
        end

        ST_HI: begin
          state_next = ST_SYNC;
          if (in_read[7:2] == 6'd0) begin
            case (tag)
              TAG_ADC0:  vld_ch_next = 4'b0001;
              TAG_ADC1:  vld_ch_next = 4'b0010;
              TAG_CADC0: vld_ch_next = 4'b0100;
              TAG_CADC1: vld_ch_next = 4'b1000;
              default:   vld_ch_next = 4'b0000;
            endcase
          end else begin
            err_next = 1'b1;
          end
        end

        default: state_next = ST_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_din     <= 8'd0;
      out_adc0    <= 10'd0;
      out_adc1    <= 10'd0;
      out_cadc0   <= 10'd0;
      out_cadc1   <= 10'd0;
      vld_din     <= 1'b0;
      vld_adc0    <= 1'b0;
      vld_adc1    <= 1'b0;
      vld_cadc0   <= 1'b0;
      vld_cadc1   <= 1'b0;
      err_frame   <= 1'b0;
      err_count   <= 8'd0;
      frame_count <= 16'd0;
    end else begin
      vld_din   <= vld_din_next;
      vld_adc0  <= vld_ch_next[0];
      vld_adc1  <= vld_ch_next[1];
      vld_cadc0 <= vld_ch_next[2];
      vld_cadc1 <= vld_ch_next[3];
      err_frame <= err_next;

      if (vld_din_next)   out_din   <= in_read;
      if (vld_ch_next[0]) out_adc0  <= sample_next;
      if (vld_ch_next[1]) out_adc1  <= sample_next;
      if (vld_ch_next[2]) out_cadc0 <= sample_next;
      if (vld_ch_next[3]) out_cadc1 <= sample_next;

      if (err_next && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
      if (vld_din_next || (vld_ch_next != 4'b0000)) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule
